dtw_cost_scheduler: RTL and testbench

- Sequences the 2-feature Euclidean distance datapath across a full template-by-test frame grid and accumulates the DTW cost matrix on the fly.
- Issues one (test, template) address pair per cycle to the frame memories feeding the distance unit.
- Consumes the in-order distance results and keeps one previous-row buffer.
- Reports the final cumulative cost D(T-1,R-1).

---
 rtl/dtw_cost_scheduler.sv | 202 ++++++++++++++++++++
 tb/tb_dtw_cost_scheduler.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dtw_cost_scheduler.sv
// dtw_cost_scheduler
//   Walks a T x R (test x template) frame grid in row-major order and issues
//   one address pair per cycle to the frame memories that feed the distance
//   unit. The in-order distance results are folded into the DTW cost matrix on
//   the fly. Only one previous-row buffer is kept. The final cost D(T-1,R-1) is
//   reported on dtw_out when done pulses.
//
// Optional build macro: DTW_BAND_EN
//   Adds band_w, which is sampled on start. Cells with |i-j| > band_w are still
//   issued, but their cost is forced to all ones.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start                 pulse; begins a run when idle (ignored otherwise)
//   test_len, tmpl_len    T and R, sampled on start; valid range 1..MAX_LEN
//   issue_valid           address pair (test_addr, tmpl_addr) valid this cycle
//   dist_valid, dist_in   distance results, in issue order, latency >= 1
//   busy                  high while issuing or draining
//   done                  one-cycle pulse at the end of a run
//   len_err               set with done when a length was out of range
//   dtw_out               final cost, held until the next accepted start
//   fsm_state             current controller state, for observation
//
// Handshake: neither interface has a ready. Every cycle with issue_valid high
// carries a pair that the memories must accept. Every cycle with dist_valid
// high (while issuing or draining) carries a result that is consumed that
// cycle. There is no backpressure in either direction.
module dtw_cost_scheduler #(
  parameter int M       = 24,
  parameter int ACC_W   = 32,
  parameter int MAX_LEN = 64,
  parameter int ADDR_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   test_len,
  input  logic [ADDR_W:0]   tmpl_len,
`ifdef DTW_BAND_EN
  input  logic [ADDR_W-1:0] band_w,
`endif
  output logic              issue_valid,
  output logic [ADDR_W-1:0] test_addr,
  output logic [ADDR_W-1:0] tmpl_addr,
  input  logic              dist_valid,
  input  logic [M-1:0]      dist_in,
  output logic              busy,
  output logic              done,
  output logic              len_err,
  output logic [ACC_W-1:0]  dtw_out,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, FIN = 2'd3} state_t;

  localparam logic [ADDR_W:0] MAX_LEN_V = (ADDR_W+1)'(MAX_LEN);

  state_t            state;
  logic [ADDR_W-1:0] t_last, r_last;   // T-1 and R-1
  logic [ADDR_W-1:0] i_cnt, j_cnt;     // issue position
  logic [ADDR_W-1:0] ri, rj;           // result position
  logic [ACC_W-1:0]  left_q;           // D(ri, rj-1)
  logic [ACC_W-1:0]  diag_q;           // D(ri-1, rj-1), captured before overwrite
  logic [ACC_W-1:0]  rowbuf [MAX_LEN];

  logic              len_ok, consume, res_last;
  logic [ACC_W-1:0]  up_v, min_ul, min3, base, d_cost;
  logic [ACC_W:0]    sum;

`ifdef DTW_BAND_EN
  logic [ADDR_W-1:0] band_q;
  logic [ADDR_W-1:0] diff;
`endif

  assign fsm_state = state;
  assign test_addr = i_cnt;
  assign tmpl_addr = j_cnt;

  assign len_ok   = (test_len != '0) && (test_len <= MAX_LEN_V) &&
                    (tmpl_len != '0) && (tmpl_len <= MAX_LEN_V);
  assign consume  = dist_valid && (state == ISSUE || state == DRAIN);
  assign res_last = (ri == t_last) && (rj == r_last);

  // One cost cell per cycle: select the predecessor, add, and saturate.
  always_comb begin
    up_v   = rowbuf[rj];
    min_ul = (up_v < left_q) ? up_v : left_q;
    min3   = (diag_q < min_ul) ? diag_q : min_ul;
    base   = '0;
    if (ri == '0 && rj == '0)
      base = '0;
    else if (ri == '0)
      base = left_q;
    else if (rj == '0)
      base = up_v;
    else
      base = min3;
    sum    = {1'b0, base} + (ACC_W+1)'(dist_in);
    d_cost = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`ifdef DTW_BAND_EN
    diff = (ri > rj) ? (ri - rj) : (rj - ri);
    if (diff > band_q)
      d_cost = '1;
`endif
  end

  // The row buffer holds the previous row of the cost matrix. Its contents are
  // never read before they are written in the current run, so it needs no reset.
  always_ff @(posedge clk) begin
    if (consume)
      rowbuf[rj] <= d_cost;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      t_last      <= '0;
      r_last      <= '0;
      i_cnt       <= '0;
      j_cnt       <= '0;
      ri          <= '0;
      rj          <= '0;
      left_q      <= '0;
      diag_q      <= '0;
      issue_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      len_err     <= 1'b0;
      dtw_out     <= '0;
`ifdef DTW_BAND_EN
      band_q      <= '0;
`endif
    end else begin
      done <= 1'b0;

      if (consume) begin
        left_q <= d_cost;
        // The old rowbuf[rj] is D(ri-1, rj), which is the diagonal for the next cell.
        diag_q <= up_v;
        if (rj == r_last) begin
          rj <= '0;
          ri <= res_last ? '0 : ri + 1'b1;
        end else begin
          rj <= rj + 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            if (len_ok) begin
              state       <= ISSUE;
              t_last      <= ADDR_W'(test_len - 1'b1);
              r_last      <= ADDR_W'(tmpl_len - 1'b1);
              i_cnt       <= '0;
              j_cnt       <= '0;
              ri          <= '0;
              rj          <= '0;
              dtw_out     <= '0;
              len_err     <= 1'b0;
              busy        <= 1'b1;
              issue_valid <= 1'b1;
`ifdef DTW_BAND_EN
              band_q      <= band_w;
`endif
            end else begin
              state   <= FIN;
              done    <= 1'b1;
              len_err <= 1'b1;
              dtw_out <= '1;
            end
          end
        end
        ISSUE: begin
          if (j_cnt == r_last) begin
            j_cnt <= '0;
            if (i_cnt == t_last) begin
              i_cnt       <= '0;
              issue_valid <= 1'b0;
              state       <= DRAIN;
            end else begin
              i_cnt <= i_cnt + 1'b1;
            end
          end else begin
            j_cnt <= j_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (consume && res_last) begin
            state   <= FIN;
            busy    <= 1'b0;
            done    <= 1'b1;
            dtw_out <= d_cost;
          end
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dtw_cost_scheduler.sv
// Directed bench for dtw_cost_scheduler. A frame-memory plus distance-unit
// stand-in returns dist_tab[i*R+j] a fixed number of cycles after each issued
// pair. Expected costs are hand-computed from the DTW recurrence.
module tb_dtw_cost_scheduler;
  localparam int M = 24, ACC_W = 32, MAX_LEN = 64, ADDR_W = 6;
  localparam int BUDGET = 6000;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W:0]   test_len = '0;
  logic [ADDR_W:0]   tmpl_len = '0;
  logic [ADDR_W-1:0] band_w = '0;
  logic              issue_valid;
  logic [ADDR_W-1:0] test_addr, tmpl_addr;
  logic              dist_valid = 1'b0;
  logic [M-1:0]      dist_in = '0;
  logic              busy, done, len_err;
  logic [ACC_W-1:0]  dtw_out;
  logic [1:0]        fsm_state;

  int checks = 0;
  int failures = 0;

  logic [M-1:0] dist_tab [4096];

  // run results
  logic [ACC_W-1:0] r_res;
  logic             r_err;
  int r_issues, r_busy, r_order_err, r_done_cyc, r_last_issue;
  logic r_fin, r_done_after;
  int busy_l1;
  bit saw_done;

  always #5 clk = ~clk;

  dtw_cost_scheduler #(.M(M), .ACC_W(ACC_W), .MAX_LEN(MAX_LEN), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .test_len(test_len), .tmpl_len(tmpl_len),
`ifdef DTW_BAND_EN
    .band_w(band_w),
`endif
    .issue_valid(issue_valid), .test_addr(test_addr), .tmpl_addr(tmpl_addr),
    .dist_valid(dist_valid), .dist_in(dist_in), .busy(busy), .done(done),
    .len_err(len_err), .dtw_out(dtw_out), .fsm_state(fsm_state)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [M-1:0] v);
    for (int k = 0; k < 4096; k++) dist_tab[k] = v;
  endtask

  // Start a run and play the distance unit until done (or the cycle budget).
  // Cycle 0 is the first cycle after the start edge. When poke is set, a second
  // start with other lengths is driven mid-run.
  task automatic run_dtw(input int t, input int r, input int lat, input bit poke,
                         input logic [ADDR_W-1:0] bw);
    int cyc;
    int exp_i, exp_j;
    int due_q[$];
    logic [M-1:0] val_q[$];
    cyc = 0; exp_i = 0; exp_j = 0;
    r_res = '0; r_err = 1'b0; r_issues = 0; r_busy = 0; r_order_err = 0;
    r_done_cyc = -1; r_last_issue = -1; r_fin = 1'b0; r_done_after = 1'b0;
    @(negedge clk);
    test_len = (ADDR_W+1)'(t);
    tmpl_len = (ADDR_W+1)'(r);
    band_w   = bw;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!r_fin && cyc < BUDGET) begin
      if (busy) r_busy++;
      if (issue_valid) begin
        if (int'(test_addr) != exp_i || int'(tmpl_addr) != exp_j) r_order_err++;
        due_q.push_back(cyc + lat);
        val_q.push_back(dist_tab[int'(test_addr) * r + int'(tmpl_addr)]);
        r_issues++;
        r_last_issue = cyc;
        if (exp_j == r - 1) begin exp_j = 0; exp_i++; end else exp_j++;
      end
      if (done) begin
        r_fin = 1'b1; r_done_cyc = cyc; r_res = dtw_out; r_err = len_err;
      end
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        void'(due_q.pop_front());
        dist_in = val_q.pop_front();
        dist_valid = 1'b1;
      end else begin
        dist_valid = 1'b0;
      end
      if (poke && cyc == 2) begin
        start = 1'b1; test_len = 7'd1; tmpl_len = 7'd1;
      end else if (poke && cyc == 3) begin
        start = 1'b0; test_len = (ADDR_W+1)'(t); tmpl_len = (ADDR_W+1)'(r);
      end
      @(negedge clk);
      cyc++;
    end
    dist_valid = 1'b0;
    start = 1'b0;
    r_done_after = done;
    if (!r_fin) check("run_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    // reset
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_issue_valid", issue_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_len_err", len_err, 0);
    check("rst_dtw_out", dtw_out, 0);
    check("rst_addrs", {test_addr, tmpl_addr}, 0);
    check("rst_state", fsm_state, 0);
    rst = 1'b0;

    // 1x1, latency 3, dist 5
    fill('0); dist_tab[0] = 24'd5;
    run_dtw(1, 1, 3, 1'b0, '0);
    check("t1r1_cost", r_res, 5);
    check("t1r1_len_err", r_err, 0);
    check("t1r1_issues", r_issues, 1);
    check("t1r1_done_cyc", r_done_cyc, 4);
    check("t1r1_done_pulse", r_done_after, 0);

    // 2x2, latency 1: D = 1,3 / 4,5
    fill('0);
    dist_tab[0] = 24'd1; dist_tab[1] = 24'd2; dist_tab[2] = 24'd3; dist_tab[3] = 24'd4;
    run_dtw(2, 2, 1, 1'b0, '0);
    check("t2r2_cost", r_res, 5);
    check("t2r2_issues", r_issues, 4);
    check("t2r2_order", r_order_err, 0);
    check("t2r2_last_issue_cyc", r_last_issue, 3);

    // 3x4 grid; rows: 3 1 4 1 / 5 9 2 6 / 5 3 5 8
    // D rows: 3 4 8 9 / 8 12 6 12 / 13 11 11 14
    fill('0);
    dist_tab[0] = 24'd3; dist_tab[1]  = 24'd1; dist_tab[2]  = 24'd4; dist_tab[3]  = 24'd1;
    dist_tab[4] = 24'd5; dist_tab[5]  = 24'd9; dist_tab[6]  = 24'd2; dist_tab[7]  = 24'd6;
    dist_tab[8] = 24'd5; dist_tab[9]  = 24'd3; dist_tab[10] = 24'd5; dist_tab[11] = 24'd8;
    run_dtw(3, 4, 1, 1'b1, '0);
    check("g34_l1_cost", r_res, 14);
    check("g34_l1_issues", r_issues, 12);
    check("g34_l1_order", r_order_err, 0);
    check("g34_l1_busy", r_busy, 13);
    busy_l1 = r_busy;
    run_dtw(3, 4, 9, 1'b1, '0);
    check("g34_l9_cost", r_res, 14);
    check("g34_l9_issues", r_issues, 12);
    check("g34_l9_busy", r_busy, 21);
    check("g34_busy_delta", r_busy - busy_l1, 8);
    repeat (4) @(negedge clk);
    check("g34_hold", dtw_out, 14);
    check("g34_idle_busy", busy, 0);

    // single row and single column: 2+3+4+5
    fill('0);
    dist_tab[0] = 24'd2; dist_tab[1] = 24'd3; dist_tab[2] = 24'd4; dist_tab[3] = 24'd5;
    run_dtw(1, 4, 2, 1'b0, '0);
    check("row_cost", r_res, 14);
    run_dtw(4, 1, 2, 1'b0, '0);
    check("col_cost", r_res, 14);
    check("col_order", r_order_err, 0);

    // invalid lengths
    run_dtw(0, 3, 1, 1'b0, '0);
    check("t0_issues", r_issues, 0);
    check("t0_len_err", r_err, 1);
    check("t0_cost", r_res, 64'hFFFF_FFFF);
    check("t0_busy", r_busy, 0);
    check("t0_done_cyc", r_done_cyc, 0);
    run_dtw(2, 65, 1, 1'b0, '0);
    check("r65_issues", r_issues, 0);
    check("r65_len_err", r_err, 1);

    // 64x64, all max distance: the diagonal path has 64 cells
    fill(24'hFF_FFFF);
    run_dtw(64, 64, 2, 1'b0, '0);
    check("g64_issues", r_issues, 4096);
    check("g64_len_err", r_err, 0);
    check("g64_cost", r_res, 64'h3FFF_FFC0);

    // reset in the middle of a 4x4 issue phase
    fill(24'd1);
    @(negedge clk);
    test_len = 7'd4; tmpl_len = 7'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_issuing", issue_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_issue", issue_valid, 0);
    check("mid_rst_dtw_out", dtw_out, 0);
    saw_done = 1'b0;
    dist_valid = 1'b1; dist_in = 24'd7;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    dist_valid = 1'b0;
    check("mid_rst_no_done", saw_done, 0);
    check("mid_rst_state", fsm_state, 0);
    dist_tab[0] = 24'd1; dist_tab[1] = 24'd2; dist_tab[2] = 24'd3; dist_tab[3] = 24'd4;
    run_dtw(2, 2, 1, 1'b0, '0);
    check("post_rst_cost", r_res, 5);

`ifdef DTW_BAND_EN
    // band 0 on 3x3 all ones: only the diagonal survives
    fill(24'd1);
    run_dtw(3, 3, 2, 1'b0, '0);
    check("band_full_cost", r_res, 3);
    run_dtw(3, 3, 2, 1'b0, 6'd5);
    check("band_wide_cost", r_res, 3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
